control_botones: RTL

Button-event scheduler that sits between the per-button debounce/minimum-hold chains and the game logic. It takes N debounced button levels and classifies each press as short or long. It arbitrates simultaneous events with fixed priority and queues them in a small FIFO, presenting one event at a time to the consumer over a valid/ready handshake.

---
 rtl/control_botones.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/control_botones.sv
// control_botones: classifies debounced button presses as short or long,
// arbitrates simultaneous events by fixed priority (lowest index first) and
// queues them in a first-word-fall-through FIFO behind a valid/ready handshake.
module control_botones #(
   parameter int N_BTN      = 4,
   parameter int LONG_TIME  = 25000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_BTN-1:0]         btn_level,
   input  logic                     evt_ready,
   output logic                     evt_valid,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     evt_long,
   output logic                     fifo_full,
   output logic                     dropped
);

   localparam int ID_W  = $clog2(N_BTN);
   localparam int CNT_W = $clog2(LONG_TIME + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TIME - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_TIME);
   localparam logic [CW-1:0]    DEPTH    = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_HELD
   } btn_state_t;

   btn_state_t       state_q [N_BTN];
   btn_state_t       state_d [N_BTN];
   logic [CNT_W-1:0] cnt_q   [N_BTN];
   logic [CNT_W-1:0] cnt_d   [N_BTN];

   logic [N_BTN-1:0] prev;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] fall;
   logic [N_BTN-1:0] req;
   logic [N_BTN-1:0] req_long;
   logic [N_BTN-1:0] pend_q;
   logic [N_BTN-1:0] pend_d;
   logic [N_BTN-1:0] type_q;
   logic [N_BTN-1:0] type_d;
   logic [N_BTN-1:0] clr;
   logic [N_BTN-1:0] still_pend;
   logic [N_BTN-1:0] accept;
   logic [N_BTN-1:0] drop_vec;

   logic [ID_W-1:0]  win_id;
   logic             win_found;
   logic             push;
   logic             pop;
   logic             full;

   logic [ID_W:0]    mem [FIFO_DEPTH];
   logic [ID_W:0]    head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CW-1:0]    count;

   // Per-button press FSMs: edge detection, hold counter, short/long requests
   always_comb begin
      rise     = btn_level & ~prev;
      fall     = ~btn_level & prev;
      req      = '0;
      req_long = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (rise[i]) begin
                  state_d[i] = S_PRESSED;
                  cnt_d[i]   = CNT_W'(1);
               end
            end
            S_PRESSED: begin
               if (fall[i]) begin
                  state_d[i] = S_IDLE;
                  req[i]     = 1'b1;
               end else if (cnt_q[i] >= CNT_LAST) begin
                  // this edge is the LONG_TIME-th sampled-high edge
                  state_d[i]  = S_HELD;
                  cnt_d[i]    = CNT_MAX;
                  req[i]      = 1'b1;
                  req_long[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            S_HELD: begin
               if (fall[i]) state_d[i] = S_IDLE;
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   // Fixed-priority arbiter and pending-flag update (lowest index wins)
   always_comb begin
      win_id    = '0;
      win_found = 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (pend_q[i] && !win_found) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
      full       = (count == DEPTH);
      push       = win_found && !full;
      pop        = evt_valid && evt_ready;
      clr        = push ? (N_BTN'(1) << win_id) : '0;
      // a request collides only with a pending bit that survives this edge
      still_pend = pend_q & ~clr;
      accept     = req & ~still_pend;
      drop_vec   = req & still_pend;
      pend_d     = still_pend | accept;
      type_d     = (type_q & ~accept) | (req_long & accept);
   end

   // State, pending flags, FIFO pointers/count and drop pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev    <= btn_level;
         pend_q  <= '0;
         type_q  <= '0;
         dropped <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         prev    <= btn_level;
         pend_q  <= pend_d;
         type_q  <= type_d;
         dropped <= |drop_vec;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   // FIFO storage: {long, id} per entry, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {type_q[win_id], win_id};
   end

   assign head      = mem[rd_ptr];
   assign evt_valid = (count != '0);
   assign fifo_full = full;
   assign evt_id    = evt_valid ? head[ID_W-1:0] : '0;
   assign evt_long  = evt_valid ? head[ID_W] : 1'b0;

endmodule
